// File: rtl/dp_ram_be.sv
// dp_ram_be - true dual-port synchronous RAM with per-byte write enables,
// a registered valid-tagged read path and a hardware zero-fill engine.
//
// After reset, and on init_req_i, the array is cleared one word per cycle.
// Both ports are ignored while init_busy_o is high.
//
// Parameters:
//   ADDR_WIDTH  word address width, depth = 2**ADDR_WIDTH words
//   DATA_WIDTH  word width in bits (multiple of 8), NB = DATA_WIDTH/8 lanes
//   OUT_REG     0: read latency 1, 1: extra output register, latency 2
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   init_req_i             pulse: start a full zero-fill (ignored while busy)
//   init_busy_o            zero-fill in progress
//   a_/b_en_i, a_/b_we_i   access request, write(1)/read(0)
//   a_/b_addr_i            word address
//   a_/b_wdata_i, a_/b_be_i write data and byte enables
//   a_/b_rdata_o           read data, holds until the next read completes
//   a_/b_rvalid_o          one-cycle pulse per completed read
//
// Optional feature, macro DP_RAM_PARITY_EN:
//   one even-parity bit per byte lane; a_/b_perr_inj_i stores inverted parity
//   on a write, a_/b_perr_o pulses with rvalid when any lane mismatches.
//
// Read-first on read/write to the same address; on a write collision port A
// wins on lanes enabled by both ports.
module dp_ram_be #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      init_req_i,
  output logic                      init_busy_o,
  input  logic                      a_en_i,
  input  logic                      a_we_i,
  input  logic [ADDR_WIDTH-1:0]     a_addr_i,
  input  logic [DATA_WIDTH-1:0]     a_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   a_be_i,
  output logic [DATA_WIDTH-1:0]     a_rdata_o,
  output logic                      a_rvalid_o,
  input  logic                      b_en_i,
  input  logic                      b_we_i,
  input  logic [ADDR_WIDTH-1:0]     b_addr_i,
  input  logic [DATA_WIDTH-1:0]     b_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   b_be_i,
  output logic [DATA_WIDTH-1:0]     b_rdata_o,
  output logic                      b_rvalid_o
`ifdef DP_RAM_PARITY_EN
  ,
  input  logic                      a_perr_inj_i,
  output logic                      a_perr_o,
  input  logic                      b_perr_inj_i,
  output logic                      b_perr_o
`endif
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  busy;

  logic                  a_wr, a_rd, b_wr, b_rd;
  logic [DATA_WIDTH-1:0] a_q1, b_q1;
  logic                  a_v1, b_v1;
`ifdef DP_RAM_PARITY_EN
  logic [NB-1:0]         a_lerr1, b_lerr1;
`endif

  // ---------------------------------------------------------------------------
  // Zero-fill FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter wraps to 0 on the final INIT write, so IDLE always holds 0
  // and a new request can start from word 0 directly.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + ADDR_WIDTH'(1);
        if (cnt == '1) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (init_req_i) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy        = (state == ST_INIT);
  assign init_busy_o = busy;

  assign a_wr = a_en_i &  a_we_i & ~busy;
  assign a_rd = a_en_i & ~a_we_i & ~busy;
  assign b_wr = b_en_i &  b_we_i & ~busy;
  assign b_rd = b_en_i & ~b_we_i & ~busy;

  // ---------------------------------------------------------------------------
  // Storage, one byte-wide array per lane
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NB; k++) begin : g_lane
    logic [7:0] mem [DEPTH];

    // Port B is applied before port A so A's assignment wins a collision.
    always_ff @(posedge clk) begin
      if (busy) begin
        mem[cnt] <= '0;
      end else begin
        if (b_wr && b_be_i[k]) mem[b_addr_i] <= b_wdata_i[8*k +: 8];
        if (a_wr && a_be_i[k]) mem[a_addr_i] <= a_wdata_i[8*k +: 8];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q1[8*k +: 8] <= '0;
        b_q1[8*k +: 8] <= '0;
      end else begin
        if (a_rd) a_q1[8*k +: 8] <= mem[a_addr_i];
        if (b_rd) b_q1[8*k +: 8] <= mem[b_addr_i];
      end
    end

`ifdef DP_RAM_PARITY_EN
    logic par [DEPTH];

    always_ff @(posedge clk) begin
      if (busy) begin
        par[cnt] <= 1'b0;
      end else begin
        if (b_wr && b_be_i[k]) par[b_addr_i] <= (^b_wdata_i[8*k +: 8]) ^ b_perr_inj_i;
        if (a_wr && a_be_i[k]) par[a_addr_i] <= (^a_wdata_i[8*k +: 8]) ^ a_perr_inj_i;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_lerr1[k] <= 1'b0;
        b_lerr1[k] <= 1'b0;
      end else begin
        if (a_rd) a_lerr1[k] <= par[a_addr_i] ^ (^mem[a_addr_i]);
        if (b_rd) b_lerr1[k] <= par[b_addr_i] ^ (^mem[b_addr_i]);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
    end else begin
      a_v1 <= a_rd;
      b_v1 <= b_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] a_q2, b_q2;
    logic                  a_v2, b_v2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q2 <= '0;
        b_q2 <= '0;
        a_v2 <= 1'b0;
        b_v2 <= 1'b0;
      end else begin
        a_v2 <= a_v1;
        b_v2 <= b_v1;
        if (a_v1) a_q2 <= a_q1;
        if (b_v1) b_q2 <= b_q1;
      end
    end

    assign a_rdata_o  = a_q2;
    assign a_rvalid_o = a_v2;
    assign b_rdata_o  = b_q2;
    assign b_rvalid_o = b_v2;

`ifdef DP_RAM_PARITY_EN
    logic a_p2, b_p2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_p2 <= 1'b0;
        b_p2 <= 1'b0;
      end else begin
        a_p2 <= a_v1 & (|a_lerr1);
        b_p2 <= b_v1 & (|b_lerr1);
      end
    end

    assign a_perr_o = a_p2;
    assign b_perr_o = b_p2;
`endif
  end else begin : g_out_direct
    assign a_rdata_o  = a_q1;
    assign a_rvalid_o = a_v1;
    assign b_rdata_o  = b_q1;
    assign b_rvalid_o = b_v1;
`ifdef DP_RAM_PARITY_EN
    // Lane error flags hold between reads; gate them with the valid pulse.
    assign a_perr_o = a_v1 & (|a_lerr1);
    assign b_perr_o = b_v1 & (|b_lerr1);
`endif
  end

endmodule
